// File: rtl/aukv_pkg.sv
// Shared constants and the decoded-entry layout for the ALU issue stage.
package aukv_pkg;

   localparam int unsigned AUKV_XLEN = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_OR  = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRA = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned BR_W  = 3;
   localparam int unsigned REG_W = 5;

   typedef struct packed {
      logic [OP_W-1:0]      operation;
      logic [AUKV_XLEN-1:0] rs1;
      logic [AUKV_XLEN-1:0] rs2;
      logic [AUKV_XLEN-1:0] cmp_a;
      logic [AUKV_XLEN-1:0] cmp_b;
      logic                 cmp_sign;
      logic                 is_branch;
      logic [BR_W-1:0]      br_type;
      logic                 sel_cmp;
      logic [REG_W-1:0]     rd_addr;
      logic                 rd_we;
      logic                 illegal;
   } aukv_dec_t;

endpackage

// File: rtl/aukv_alu_issue_if.sv
// Upstream (register read) and downstream (execute) handshake bundle of the issue stage.
interface aukv_alu_issue_if #(parameter int unsigned XLEN = 32);
   logic            i_valid;
   logic            o_ready;
   logic [31:0]     i_instr;
   logic [XLEN-1:0] i_pc;
   logic [XLEN-1:0] i_rs1_data;
   logic [XLEN-1:0] i_rs2_data;
   logic            o_valid;
   logic            i_ready;
   logic [3:0]      o_operation;
   logic [XLEN-1:0] o_rs1;
   logic [XLEN-1:0] o_rs2;
   logic [XLEN-1:0] o_cmp_a;
   logic [XLEN-1:0] o_cmp_b;
   logic            o_cmp_sign;
   logic            o_is_branch;
   logic [2:0]      o_br_type;
   logic            o_sel_cmp;
   logic [4:0]      o_rd_addr;
   logic            o_rd_we;
   logic            o_illegal;

   modport slave (
      input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ready,
      output o_ready, o_valid, o_operation, o_rs1, o_rs2, o_cmp_a, o_cmp_b,
             o_cmp_sign, o_is_branch, o_br_type, o_sel_cmp, o_rd_addr, o_rd_we, o_illegal
   );

   modport master (
      output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ready,
      input  o_ready, o_valid, o_operation, o_rs1, o_rs2, o_cmp_a, o_cmp_b,
             o_cmp_sign, o_is_branch, o_br_type, o_sel_cmp, o_rd_addr, o_rd_we, o_illegal
   );
endinterface

// File: rtl/aukv_skid_buf.sv
// Two-entry valid/ready register: main drives the outputs, skid catches one entry during a stall.
module aukv_skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_flush,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         main_vld_q, main_vld_d;
   logic         skid_vld_q, skid_vld_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         accept;

   assign o_ready = ~skid_vld_q;
   assign o_valid = main_vld_q;
   assign o_data  = main_q;
   assign accept  = i_valid & ~skid_vld_q;

   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_d     = main_q;
      skid_d     = skid_q;
      if (i_flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (~main_vld_q | i_ready) begin
         // skid is older than anything on the input, so it refills main first
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = accept;
            if (accept) main_d = i_data;
         end
      end else if (accept) begin
         skid_d     = i_data;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

endmodule

// File: rtl/aukv_alu_issue.sv
// RV32I issue/decode stage producing ALU/comparator controls behind a skid buffer.
// Build option: AUKV_SLT_EN enables SLT/SLTI/SLTU/SLTIU via the comparator path.
module aukv_alu_issue
   import aukv_pkg::*;
#(
   parameter int unsigned XLEN = AUKV_XLEN
) (
   input logic              i_clk,
   input logic              i_rstn,
   input logic              i_flush,
   aukv_alu_issue_if.slave  bus
);

   aukv_dec_t       dec_d;
   aukv_dec_t       dec_q;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic            alt;
   logic [XLEN-1:0] imm_i, imm_b, imm_u;
   logic            is_r;
   logic [XLEN-1:0] src2;
   logic [XLEN-1:0] shamt;
   logic            unused_rs1_idx;

   assign opcode = bus.i_instr[6:0];
   assign funct3 = bus.i_instr[14:12];
   assign rd     = bus.i_instr[11:7];
   assign alt    = bus.i_instr[30];
   assign imm_i  = {{(XLEN-12){bus.i_instr[31]}}, bus.i_instr[31:20]};
   assign imm_b  = {{(XLEN-13){bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[7],
                    bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
   assign imm_u  = {bus.i_instr[31:12], 12'b0};
   assign unused_rs1_idx = ^bus.i_instr[19:15];

   always_comb begin
      dec_d = '0;
      is_r  = (opcode == OPC_OP);
      src2  = is_r ? bus.i_rs2_data : imm_i;
      shamt = {{(XLEN-5){1'b0}}, src2[4:0]};
      case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            dec_d.rs1     = bus.i_rs1_data;
            dec_d.rs2     = src2;
            dec_d.rd_addr = rd;
            dec_d.rd_we   = |rd;
            case (funct3)
               F3_ADD: dec_d.operation = (is_r & alt) ? ALU_SUB : ALU_ADD;
               F3_SLL: begin
                  dec_d.operation = ALU_SLL;
                  dec_d.rs2       = shamt;
               end
               F3_XOR: dec_d.operation = ALU_XOR;
               F3_SR: begin
                  dec_d.operation = alt ? ALU_SRA : ALU_SRL;
                  dec_d.rs2       = shamt;
               end
               F3_OR:  dec_d.operation = ALU_OR;
               F3_AND: dec_d.operation = ALU_AND;
               default: begin
`ifdef AUKV_SLT_EN
                  dec_d.sel_cmp  = 1'b1;
                  dec_d.cmp_a    = bus.i_rs1_data;
                  dec_d.cmp_b    = src2;
                  dec_d.cmp_sign = (funct3 == F3_SLT);
`else
                  dec_d         = '0;
                  dec_d.illegal = 1'b1;
`endif
               end
            endcase
         end
         OPC_BRANCH: begin
            case (funct3)
               BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: begin
                  dec_d.rs1       = bus.i_pc;
                  dec_d.rs2       = imm_b;
                  dec_d.operation = ALU_ADD;
                  dec_d.cmp_a     = bus.i_rs1_data;
                  dec_d.cmp_b     = bus.i_rs2_data;
                  dec_d.cmp_sign  = ~funct3[1];
                  dec_d.is_branch = 1'b1;
                  dec_d.br_type   = funct3;
               end
               default: dec_d.illegal = 1'b1;
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_d.rs1     = (opcode == OPC_AUIPC) ? bus.i_pc : '0;
            dec_d.rs2     = imm_u;
            dec_d.rd_addr = rd;
            dec_d.rd_we   = |rd;
         end
         default: dec_d.illegal = 1'b1;
      endcase
   end

   aukv_skid_buf #(.W($bits(aukv_dec_t))) u_skid (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_flush (i_flush),
      .i_valid (bus.i_valid),
      .o_ready (bus.o_ready),
      .i_data  (dec_d),
      .o_valid (bus.o_valid),
      .i_ready (bus.i_ready),
      .o_data  (dec_q)
   );

   assign bus.o_operation = dec_q.operation;
   assign bus.o_rs1       = dec_q.rs1;
   assign bus.o_rs2       = dec_q.rs2;
   assign bus.o_cmp_a     = dec_q.cmp_a;
   assign bus.o_cmp_b     = dec_q.cmp_b;
   assign bus.o_cmp_sign  = dec_q.cmp_sign;
   assign bus.o_is_branch = dec_q.is_branch;
   assign bus.o_br_type   = dec_q.br_type;
   assign bus.o_sel_cmp   = dec_q.sel_cmp;
   assign bus.o_rd_addr   = dec_q.rd_addr;
   assign bus.o_rd_we     = dec_q.rd_we;
   assign bus.o_illegal   = dec_q.illegal;

endmodule

// File: tb/tb_aukv_alu_issue.sv
// Scoreboard bench for aukv_alu_issue: reference decode model feeds a FIFO of expected entries.
module tb_aukv_alu_issue;
   import aukv_pkg::*;

   logic clk;
   logic rstn;
   logic flush;
   int   n_checks;
   int   n_fail;
   aukv_dec_t exp_q[$];

   aukv_alu_issue_if #(.XLEN(32)) bus ();

   aukv_alu_issue dut (
      .i_clk   (clk),
      .i_rstn  (rstn),
      .i_flush (flush),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   // reference decoder, written straight from the ISA field layout
   function automatic aukv_dec_t model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b);
      aukv_dec_t  e;
      logic [2:0]  f3;
      logic [4:0]  rdx;
      logic [31:0] ii, ib, op2;
      logic        rtype;
      e     = '0;
      f3    = ins[14:12];
      rdx   = ins[11:7];
      ii    = {{20{ins[31]}}, ins[31:20]};
      ib    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      rtype = (ins[6:0] == 7'b0110011);
      op2   = rtype ? b : ii;
      if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) begin
         if (f3 == 3'b010 || f3 == 3'b011) begin
`ifdef AUKV_SLT_EN
            e.sel_cmp = 1'b1; e.cmp_a = a; e.cmp_b = op2; e.cmp_sign = (f3 == 3'b010);
            e.rs1 = a; e.rs2 = op2; e.rd_addr = rdx; e.rd_we = (rdx != 5'd0);
`else
            e.illegal = 1'b1;
`endif
         end else begin
            e.rs1 = a; e.rs2 = op2; e.rd_addr = rdx; e.rd_we = (rdx != 5'd0);
            if (f3 == 3'b001 || f3 == 3'b101) e.rs2 = {27'd0, op2[4:0]};
            case (f3)
               3'b000:  e.operation = (rtype && ins[30]) ? 4'd1 : 4'd0;
               3'b001:  e.operation = 4'd5;
               3'b100:  e.operation = 4'd4;
               3'b101:  e.operation = ins[30] ? 4'd6 : 4'd7;
               3'b110:  e.operation = 4'd2;
               default: e.operation = 4'd3;
            endcase
         end
      end else if (ins[6:0] == 7'b1100011) begin
         if (f3 == 3'b010 || f3 == 3'b011) e.illegal = 1'b1;
         else begin
            e.rs1 = pc; e.rs2 = ib; e.cmp_a = a; e.cmp_b = b; e.cmp_sign = !f3[1];
            e.is_branch = 1'b1; e.br_type = f3;
         end
      end else if (ins[6:0] == 7'b0110111 || ins[6:0] == 7'b0010111) begin
         e.rs1 = ins[5] ? 32'd0 : pc;
         e.rs2 = {ins[31:12], 12'd0}; e.rd_addr = rdx; e.rd_we = (rdx != 5'd0);
      end else begin
         e.illegal = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0: r[6:0] = 7'b0110011;
         1: r[6:0] = 7'b0010011;
         2: r[6:0] = 7'b1100011;
         3: r[6:0] = 7'b0110111;
         4: r[6:0] = 7'b0010111;
         5: begin r[6:0] = 7'b0110011; r[31:25] = {1'b0, r[30], 5'd0}; end
         default: r[6:0] = 7'b0000011;
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rstn) begin
         exp_q.delete();
         chk("rst_valid", 32'(bus.o_valid), 32'd0);
         chk("rst_ready", 32'(bus.o_ready), 32'd1);
         chk("rst_rs1", bus.o_rs1, 32'd0);
         chk("rst_rs2", bus.o_rs2, 32'd0);
         chk("rst_flags", 32'({bus.o_operation, bus.o_rd_we, bus.o_illegal, bus.o_is_branch}), 32'd0);
      end else if (flush) begin
         exp_q.delete();
      end else begin
         chk("o_valid", 32'(bus.o_valid), 32'(exp_q.size() > 0));
         chk("o_ready", 32'(bus.o_ready), 32'(exp_q.size() < 2));
         if (bus.o_valid && exp_q.size() > 0) begin
            chk("operation", 32'(bus.o_operation), 32'(exp_q[0].operation));
            chk("rs1", bus.o_rs1, exp_q[0].rs1);
            chk("rs2", bus.o_rs2, exp_q[0].rs2);
            chk("cmp_a", bus.o_cmp_a, exp_q[0].cmp_a);
            chk("cmp_b", bus.o_cmp_b, exp_q[0].cmp_b);
            chk("rd_addr", 32'(bus.o_rd_addr), 32'(exp_q[0].rd_addr));
            chk("ctl", 32'({bus.o_cmp_sign, bus.o_is_branch, bus.o_br_type, bus.o_sel_cmp,
                            bus.o_rd_we, bus.o_illegal}),
                32'({exp_q[0].cmp_sign, exp_q[0].is_branch, exp_q[0].br_type, exp_q[0].sel_cmp,
                     exp_q[0].rd_we, exp_q[0].illegal}));
            if (bus.i_ready) void'(exp_q.pop_front());
         end
         if (bus.i_valid && bus.o_ready)
            exp_q.push_back(model(bus.i_instr, bus.i_pc, bus.i_rs1_data, bus.i_rs2_data));
      end
   end

   task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
      logic acc;
      acc = 1'b0;
      bus.i_valid = 1'b1; bus.i_instr = ins; bus.i_pc = pc;
      bus.i_rs1_data = a; bus.i_rs2_data = b;
      for (int t = 0; t < 20 && !acc; t++) begin
         @(negedge clk);
         acc = bus.o_ready;
         @(posedge clk);
         #1;
      end
      bus.i_valid = 1'b0;
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bus.i_ready = 1'b1;
      bus.i_valid = 1'b0;
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rstn = 1'b0; flush = 1'b0;
      bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_instr = '0; bus.i_pc = '0;
      bus.i_rs1_data = '0; bus.i_rs2_data = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // directed decode cases
      send(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7);
      send(enc_i(12'h403, 5'd4, 3'b101, 5'd4, 7'b0010011), 32'h4, 32'hF000_0000, 32'd9);
      send(enc_i(12'd31, 5'd7, 3'b001, 5'd6, 7'b0010011), 32'h8, 32'h1, 32'd0);
      send(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd0), 32'hC, 32'd9, 32'd4);
      send(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b110), 32'h100, 32'd1, 32'hFFFF_FFFF);
      send(enc_b(13'h0010, 5'd2, 5'd1, 3'b010), 32'h104, 32'd1, 32'd2);
      send(enc_r(7'd0, 5'd2, 5'd1, 3'b011, 5'd5), 32'h108, 32'd3, 32'd4);
      send(enc_i(12'hFFF, 5'd1, 3'b010, 5'd5, 7'b0010011), 32'h10C, 32'hFFFF_FFFE, 32'd0);
      send(enc_i(12'h004, 5'd1, 3'b010, 5'd8, 7'b0000011), 32'h110, 32'd1, 32'd2);
      send({20'hABCDE, 5'd9, 7'b0110111}, 32'h114, 32'd1, 32'd2);
      send({20'h80001, 5'd9, 7'b0010111}, 32'h118, 32'd1, 32'd2);
      drain();

      // stream of four with a three-cycle downstream stall
      fork
         begin
            for (int k = 0; k < 4; k++)
               send(enc_r(7'd0, 5'd2, 5'd1, 3'b110, 5'(k + 10)), 32'(k * 4), 32'(k), 32'h100);
         end
         begin
            @(posedge clk);
            #1 bus.i_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.i_ready = 1'b1;
         end
      join
      drain();

      // flush with both entries held and a new entry presented
      bus.i_ready = 1'b0;
      send(enc_r(7'd0, 5'd2, 5'd1, 3'b100, 5'd20), 32'h200, 32'd1, 32'd2);
      send(enc_r(7'd0, 5'd2, 5'd1, 3'b111, 5'd21), 32'h204, 32'd3, 32'd4);
      bus.i_valid = 1'b1; bus.i_instr = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd22);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0; bus.i_valid = 1'b0;
      chk("flush_valid", 32'(bus.o_valid), 32'd0);
      chk("flush_ready", 32'(bus.o_ready), 32'd1);
      bus.i_ready = 1'b1;
      send(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd23), 32'h20C, 32'd11, 32'd12);
      drain();

      // asynchronous reset while two entries are in flight
      bus.i_ready = 1'b0;
      send(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd24), 32'h300, 32'd1, 32'd1);
      send(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd25), 32'h304, 32'd2, 32'd2);
      #2 rstn = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.o_valid), 32'd0);
      chk("arst_rs1", bus.o_rs1, 32'd0);
      chk("arst_rd", 32'(bus.o_rd_addr), 32'd0);
      @(posedge clk);
      #1 rstn = 1'b1; bus.i_ready = 1'b1;

      // random traffic with random backpressure and occasional flush
      for (int c = 0; c < 300; c++) begin
         bus.i_valid    = 1'($urandom_range(0, 1));
         bus.i_ready    = ($urandom_range(0, 3) != 0);
         bus.i_instr    = rand_instr();
         bus.i_pc       = $urandom;
         bus.i_rs1_data = $urandom;
         bus.i_rs2_data = $urandom;
         flush          = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         #1;
      end
      flush = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
